// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: steps a 2-to-4 display decoder through the enabled digits.
// Each slot is DIV cycles long. The first BLANK cycles hold en low to suppress
// ghosting, and en is high for the rest of the slot. frame_done pulses when the
// scan wraps back to the lowest-indexed enabled digit.
module digit_scan_ctrl #(
  parameter int unsigned DIV   = 8,
  parameter int unsigned BLANK = 2,
  parameter int unsigned CW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] mask,
  output logic [1:0] sel,
  output logic       en,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? (BLANK - 1) : 0);
  localparam state_t        ST_SLOT0   = (BLANK == 0) ? ST_DRIVE : ST_BLANK;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic          r_en;
  logic          r_frame_done;
  logic          r_busy;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_sel_nxt;
  logic          w_fd_nxt;
  logic [1:0]    w_first_sel;
  logic [1:0]    w_after_sel;

  // Lowest set bit of m.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = '0;
    for (int unsigned i = 4; i >= 1; i--) begin
      if (m[i-1]) lowest_set = 2'(i - 1);
    end
  endfunction

  // First set bit searching upward from cur+1 and wrapping 3->0. If cur is the
  // only set bit, the search returns cur.
  function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] idx;
    next_set = cur;
    for (int unsigned k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) next_set = idx;
    end
  endfunction

  assign w_first_sel = lowest_set(mask);
  assign w_after_sel = next_set(mask, r_sel);

  // Next-state, slot counter, digit index and wrap-pulse logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_fd_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (run && (mask != '0)) begin
          w_sel_nxt   = w_first_sel;
          w_state_nxt = ST_SLOT0;
        end
      end
      ST_BLANK: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == BLANK_LAST) w_state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (r_cnt == DIV_LAST) begin
          w_cnt_nxt = '0;
          if (!run || (mask == '0)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_sel_nxt   = w_after_sel;
            w_state_nxt = ST_SLOT0;
            w_fd_nxt    = (w_after_sel <= r_sel);
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers. en and busy are decoded from the next state so
  // that they line up with the state they describe while still being registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_sel        <= '0;
      r_en         <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sel        <= w_sel_nxt;
      r_en         <= (w_state_nxt == ST_DRIVE);
      r_frame_done <= w_fd_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  assign sel        = r_sel;
  assign en         = r_en;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed testbench for digit_scan_ctrl with DIV=8 and BLANK=2.
module tb_digit_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] mask;
  logic [1:0] sel;
  logic       en;
  logic       frame_done;
  logic       busy;

  int unsigned n_tests;
  int unsigned n_fail;

  digit_scan_ctrl #(.DIV(8), .BLANK(2), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .mask      (mask),
    .sel       (sel),
    .en        (en),
    .frame_done(frame_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    mask  = 4'b0000;
    step();
    step();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_en", 32'(en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
  endtask

  // Scans nslots slots. Slot s drives seq[s % len]. Within each 8-cycle slot,
  // en is 0 for the first 2 cycles and 1 for the remaining 6. frame_done is
  // high only in the first cycle of a slot that starts a new pass through seq.
  task automatic scan(input logic [1:0] seq [4], input int unsigned len,
                      input int unsigned nslots);
    int unsigned slot;
    int unsigned pos;
    for (int unsigned n = 0; n < nslots * 8; n++) begin
      step();
      slot = n / 8;
      pos  = n % 8;
      check("scan_sel", 32'(sel), 32'(seq[slot % len]));
      check("scan_en", 32'(en), (pos >= 2) ? 32'd1 : 32'd0);
      check("scan_busy", 32'(busy), 32'd1);
      check("scan_fd", 32'(frame_done),
            (pos == 0 && slot > 0 && (slot % len) == 0) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    logic [1:0] seq [4];
    n_tests = 0;
    n_fail  = 0;

    // All four digits in order, 0,1,2,3,0.
    do_reset();
    run = 1'b1; mask = 4'b1111;
    seq = '{2'd0, 2'd1, 2'd2, 2'd3};
    scan(seq, 4, 5);

    // Digits 0 and 2 alternate.
    do_reset();
    run = 1'b1; mask = 4'b0101;
    seq = '{2'd0, 2'd2, 2'd0, 2'd0};
    scan(seq, 2, 4);

    // Single digit 3. frame_done pulses at the start of every slot after the first.
    do_reset();
    run = 1'b1; mask = 4'b1000;
    seq = '{2'd3, 2'd3, 2'd3, 2'd3};
    scan(seq, 1, 3);

    // run=1 with mask=0 stays idle, and a non-zero mask starts a slot.
    do_reset();
    run = 1'b1; mask = 4'b0000;
    for (int unsigned i = 0; i < 20; i++) begin
      step();
      check("m0_busy", 32'(busy), 32'd0);
      check("m0_en", 32'(en), 32'd0);
    end
    mask = 4'b0010;
    step();
    check("m2_sel", 32'(sel), 32'd1);
    check("m2_busy", 32'(busy), 32'd1);
    check("m2_en_blank", 32'(en), 32'd0);
    step();
    check("m2_en_blank2", 32'(en), 32'd0);
    step();
    check("m2_en_drive", 32'(en), 32'd1);

    // Dropping run mid-slot takes effect only at the end of the slot.
    do_reset();
    run = 1'b1; mask = 4'b0100;
    for (int unsigned i = 0; i < 4; i++) step();
    check("rd_sel", 32'(sel), 32'd2);
    check("rd_en_cnt3", 32'(en), 32'd1);
    run = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      check("rd_en_hold", 32'(en), 32'd1);
      check("rd_busy_hold", 32'(busy), 32'd1);
    end
    step();
    check("rd_idle_en", 32'(en), 32'd0);
    check("rd_idle_busy", 32'(busy), 32'd0);
    check("rd_idle_sel", 32'(sel), 32'd2);
    check("rd_idle_fd", 32'(frame_done), 32'd0);
    step();
    check("rd_idle2_busy", 32'(busy), 32'd0);

    // Asynchronous reset during DRIVE, then a clean restart.
    do_reset();
    run = 1'b1; mask = 4'b1111;
    for (int unsigned i = 0; i < 14; i++) step();
    check("ar_pre_sel", 32'(sel), 32'd1);
    check("ar_pre_en", 32'(en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_en", 32'(en), 32'd0);
    check("ar_sel", 32'(sel), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("ar_rs_sel", 32'(sel), 32'd0);
    check("ar_rs_busy", 32'(busy), 32'd1);
    check("ar_rs_en0", 32'(en), 32'd0);
    step();
    check("ar_rs_en1", 32'(en), 32'd0);
    step();
    check("ar_rs_en2", 32'(en), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Sequential scan controller that generates the 2-bit select and enable pair driving the 2-to-4 decoder stage directly downstream.
- The decoder's one-hot outputs enable one of four multiplexed display digits.
- Cycles through the enabled digits in a fixed order, holding each for a programmable slot.
- Inserts a blanking interval with enable low at the start of every slot to suppress ghosting, and flags frame completion.

Parameters:
- DIV, 8, clock cycles per digit slot; legal range 2..2^CW-1.
- BLANK, 2, blanking cycles at the start of each slot with en=0; legal range 0..DIV-1.
- CW, 8, slot counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level; 1 = scanning requested.
- mask  input  4  digit enable; bit i=1 means digit i is included in the scan.
- sel  output  2  digit index to the decoder.
- en  output  1  decoder enable; 1 = drive the digit selected by sel.
- frame_done  output  1  one-cycle pulse when the scan wraps from the last enabled digit to the first.
- busy  output  1  1 whenever the state is not IDLE.

Behaviour:
Interface and outputs:
- One clock domain: clk.
- Reset is asynchronous and active-low (rst_n). Assertion immediately forces state=IDLE, sel=0, en=0, frame_done=0, busy=0, cnt=0.
- All outputs are registered. No combinational path exists from inputs to outputs.

States: IDLE, BLANK, DRIVE.
- IDLE:
  - en=0; sel holds its last value; busy=0.
  - Leaves IDLE on the first edge where run=1 and mask!=0.
  - On that edge: sel = lowest set bit of mask, cnt=0. Next state is BLANK, or DRIVE if BLANK==0.
  - With run=1 and mask=0, the block stays in IDLE.
- BLANK:
  - en=0; cnt increments each cycle.
  - Moves to DRIVE on the edge where cnt==BLANK-1.
- DRIVE:
  - en=1; cnt increments.
  - On the edge where cnt==DIV-1 (slot end), the block evaluates the slot-end rules below.

Slot-end rules, evaluated only at slot end; mask and run are sampled only here once scanning has started:
- If run=0 or mask=0: go to IDLE; en=0 next cycle; no frame_done.
- Otherwise:
  - next sel = first set mask bit searching upward from sel+1, wrapping 3->0. The current digit is re-selected if it is the only set bit.
  - cnt=0; go to BLANK, or DRIVE if BLANK==0.
  - If next index <= current index (wrap): frame_done=1 for exactly that one cycle.
- If the current digit's mask bit cleared mid-slot, the slot still completes; the digit is skipped thereafter.

Slot timing and counter:
- Each slot is exactly DIV cycles: BLANK cycles with en=0, then DIV-BLANK cycles with en=1.
- Back-to-back slots have no extra cycles.
- cnt never exceeds DIV-1.
- busy=1 in BLANK and DRIVE.

Other boundary conditions:
- run toggling mid-slot has no effect until slot end.
- A single enabled digit gives frame_done once per slot.
- rst_n asserted mid-DRIVE drops en in the same cycle (asynchronous). After release, the block restarts from IDLE.

Test Plan:
- DIV=8, BLANK=2, mask=1111, run=1 after reset -> sel sequence 0,1,2,3,0,...
  - Each slot is 8 cycles: en=0 for 2 cycles, then en=1 for 6.
  - frame_done pulses once every 32 cycles, on the 3->0 transition.
- mask=0101, run=1 -> sel alternates 0,2,0,2 with 8-cycle slots; frame_done every 16 cycles on the 2->0 change.
- mask=1000 -> sel stays 3; en pattern 2 low / 6 high repeating; frame_done pulses every 8 cycles.
- run=1 with mask=0 for 20 cycles, then mask=0010 -> busy=0 and en=0 throughout the first phase. One cycle after mask changes: sel=1, busy=1, BLANK entered.
- run dropped at cnt=3 of a DRIVE slot on digit 2 -> en stays 1 through cnt=7. Then IDLE: en=0, busy=0, sel holds 2, frame_done=0.
- rst_n pulled low at cnt=5 of DRIVE -> en=0, sel=0, busy=0 before the next clock edge. After rst_n release with run=1, mask=1111: scan restarts at sel=0 with a full BLANK interval.
